// File: rtl/dmem_access_unit_if.sv
// Data-memory bus bundle: sized req/ack transaction from the access unit to RAM/bus.
interface dmem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic                    mem_ack;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store controller: turns a pipeline request into one byte-enabled
// req/ack bus transaction, stalls while outstanding, and returns extended load data.
module dmem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  fault_o,
  output logic                  timeout_o,
  dmem_access_unit_if.master    bus
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         req_q, req_d;
  logic                         we_q, we_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [NUM_LANES-1:0]         be_q, be_d;
  logic [2:0]                   f3_q, f3_d;
  logic [1:0]                   off_q, off_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic                         fault_q, fault_d;
  logic                         timeout_q, timeout_d;
  logic                         stall;

  logic                         req_any, is_rd, f3_ok, misaligned, legal;
  logic [NUM_LANES-1:0]         be_new;
  logic [NUM_LANES-1:0][7:0]    st_lanes;
  logic [NUM_LANES-1:0][7:0]    rd_lanes;
  logic [7:0]                   ld_byte;
  logic [15:0]                  ld_half;
  logic [DATA_WIDTH-1:0]        ld_fmt;

  // Read wins when both strobes are up, so legality is judged as a load then.
  assign req_any = req_read | req_write;
  assign is_rd   = req_read;

  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = is_rd;
      default:                f3_ok = 1'b0;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    legal = f3_ok && !misaligned;
  end

  always_comb begin
    be_new = '1;
    if (!is_rd) begin
      case (req_funct3[1:0])
        2'b00:   be_new = 4'b0001 << req_addr[1:0];
        2'b01:   be_new = 4'b0011 << req_addr[1:0];
        default: be_new = '1;
      endcase
    end
  end

  // Store data replicated so every enabled lane sees the right byte.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_st_lane
    assign st_lanes[i] = (req_funct3[1:0] == 2'b00) ? req_wdata[7:0] :
                         (req_funct3[1:0] == 2'b01) ? req_wdata[8*(i%2) +: 8] :
                                                      req_wdata[8*i +: 8];
  end

  assign rd_lanes = bus.mem_rdata;

  always_comb begin
    ld_byte = rd_lanes[off_q];
    ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'b0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'b0, ld_half};
      default: ld_fmt = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    f3_d      = f3_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    fault_d   = 1'b0;
    timeout_d = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (legal) begin
            stall   = 1'b1;
            state_d = WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = !is_rd;
            addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_d = st_lanes;
            be_d    = be_new;
            f3_d    = req_funct3;
            off_d   = req_addr[1:0];
          end else begin
            fault_d = 1'b1;
            rdata_d = '0;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (bus.mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = ld_fmt;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          req_d     = 1'b0;
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_o       = stall && !rst;
  assign rdata_o       = rdata_q;
  assign fault_o       = fault_q;
  assign timeout_o     = timeout_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: vector table with a bus responder and scoreboard queue,
// plus hand sequences for faults, timeout, late ack and reset during WAIT.
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        stall_o, fault_o, timeout_o;
  logic [31:0] rdata_o;

  int n_checks = 0;
  int n_errors = 0;

  logic        auto_mode = 1'b1;
  logic        auto_ack  = 1'b0;
  logic        man_ack   = 1'b0;
  logic [31:0] rdata_word = '0;
  int          ack_delay  = 0;

  dmem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  assign bus.mem_ack   = auto_mode ? auto_ack : man_ack;
  assign bus.mem_rdata = rdata_word;

  dmem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .stall_o(stall_o), .rdata_o(rdata_o), .fault_o(fault_o), .timeout_o(timeout_o),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    logic [31:0] mem_word;
    int          dly;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;
    logic        exp_we;
  } vec_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3,
                              input logic [31:0] word, input int dly, input logic [31:0] ea,
                              input logic [31:0] ew, input logic [3:0] ebe, input logic ewe,
                              input logic [31:0] er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.f3 = f3;
    v.mem_word = word; v.dly = dly; v.exp_addr = ea; v.exp_wdata = ew;
    v.exp_be = ebe; v.exp_we = ewe; v.exp_rdata = er;
    return v;
  endfunction

  // Bus responder: ack after ack_delay cycles of mem_req being high.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        if (wcnt == ack_delay) begin auto_ack = 1'b1; wcnt = 0; end
        else begin auto_ack = 1'b0; wcnt++; end
      end else begin
        auto_ack = 1'b0; wcnt = 0;
      end
    end
  end

  // Scoreboard: bus fields checked on the ack cycle, load data in the following DONE cycle.
  initial begin
    logic done_pend;
    exp_t e;
    done_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (done_pend) begin
        done_pend = 1'b0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("done_rdata", rdata_o, e.rdata);
          chk("done_stall", {31'b0, stall_o}, 32'd0);
          chk("done_timeout", {31'b0, timeout_o}, 32'd0);
        end
      end
      if (bus.mem_req && bus.mem_ack && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("bus_addr", bus.mem_addr, e.addr);
        chk("bus_be", {28'b0, bus.mem_be}, {28'b0, e.be});
        chk("bus_we", {31'b0, bus.mem_we}, {31'b0, e.we});
        if (e.we) chk("bus_wdata", bus.mem_wdata, e.wdata);
        done_pend = 1'b1;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   stalls;
    logic finished;
    @(posedge clk); #1;
    req_read = v.rd; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_funct3 = v.f3;
    ack_delay = v.dly; rdata_word = v.mem_word;
    e.addr = v.exp_addr; e.wdata = v.exp_wdata; e.rdata = v.exp_rdata;
    e.be = v.exp_be; e.we = v.exp_we;
    exp_q.push_back(e);
    stalls = 0;
    finished = 1'b0;
    for (int c = 0; c < 20 && !finished; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      @(posedge clk); #1;
      req_read = 1'b0; req_write = 1'b0;
      if (exp_q.size() == 0) finished = 1'b1;
    end
    if (!finished) begin
      n_checks++; n_errors++;
      $display("FAIL vec_complete: transaction at %h never completed", v.addr);
      exp_q.delete();
    end else begin
      chk("stall_cycles", stalls, 32'(2 + v.dly));
    end
  endtask

  task automatic run_fault(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [2:0] f3);
    @(posedge clk); #1;
    req_read = rd; req_write = wr; req_addr = addr; req_funct3 = f3; req_wdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("fault_req_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    req_read = 1'b0; req_write = 1'b0;
    @(negedge clk);
    chk("fault_pulse", {31'b0, fault_o}, 32'd1);
    chk("fault_no_req", {31'b0, bus.mem_req}, 32'd0);
    chk("fault_rdata", rdata_o, 32'd0);
    chk("fault_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fault_clear", {31'b0, fault_o}, 32'd0);
    chk("fault_no_req2", {31'b0, bus.mem_req}, 32'd0);
  endtask

  initial begin
    int nreq;
    vecs[0]  = mk(1,0,32'h100,32'h0,3'b010,32'hDEADBEEF,0,32'h100,32'h0,4'b1111,0,32'hDEADBEEF);
    vecs[1]  = mk(1,0,32'h103,32'h0,3'b000,32'h80123456,0,32'h100,32'h0,4'b1111,0,32'hFFFFFF80);
    vecs[2]  = mk(1,0,32'h103,32'h0,3'b100,32'h80123456,0,32'h100,32'h0,4'b1111,0,32'h00000080);
    vecs[3]  = mk(0,1,32'h202,32'h1234ABCD,3'b001,32'h0,1,32'h200,32'hABCDABCD,4'b1100,1,32'h00000080);
    vecs[4]  = mk(1,0,32'h206,32'h0,3'b001,32'h80017FFF,2,32'h204,32'h0,4'b1111,0,32'hFFFF8001);
    vecs[5]  = mk(1,0,32'h204,32'h0,3'b101,32'h8001F00F,0,32'h204,32'h0,4'b1111,0,32'h0000F00F);
    vecs[6]  = mk(1,0,32'h204,32'h0,3'b001,32'h0000F00F,1,32'h204,32'h0,4'b1111,0,32'hFFFFF00F);
    vecs[7]  = mk(0,1,32'h301,32'hFFFFFF5A,3'b000,32'h0,0,32'h300,32'h5A5A5A5A,4'b0010,1,32'hFFFFF00F);
    vecs[8]  = mk(0,1,32'h40C,32'hCAFEF00D,3'b010,32'h0,2,32'h40C,32'hCAFEF00D,4'b1111,1,32'hFFFFF00F);
    vecs[9]  = mk(1,0,32'h402,32'h0,3'b000,32'h007F0000,0,32'h400,32'h0,4'b1111,0,32'h0000007F);
    vecs[10] = mk(1,0,32'h401,32'h0,3'b100,32'h0000C300,0,32'h400,32'h0,4'b1111,0,32'h000000C3);
    vecs[11] = mk(1,1,32'h500,32'h11111111,3'b010,32'h13572468,0,32'h500,32'h0,4'b1111,0,32'h13572468);
    vecs[12] = mk(0,1,32'h503,32'h000000A5,3'b000,32'h0,1,32'h500,32'hA5A5A5A5,4'b1000,1,32'h13572468);

    // Reset: a legal request while rst is high must not stall.
    rst = 1'b1;
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_wdata = '0; req_funct3 = 3'b010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
    req_read = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_fault", {31'b0, fault_o}, 32'd0);
    chk("rst_timeout", {31'b0, timeout_o}, 32'd0);
    chk("rst_be", {28'b0, bus.mem_be}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_we", {31'b0, bus.mem_we}, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    run_fault(1, 0, 32'h101, 3'b010);
    run_fault(0, 1, 32'h201, 3'b001);
    run_fault(0, 1, 32'h200, 3'b100);
    run_fault(1, 0, 32'h200, 3'b011);

    // Timeout: no ack, request drops after 4 WAIT cycles. Prime rdata_o first.
    run_vec(vecs[0]);
    auto_mode = 1'b0; man_ack = 1'b0;
    @(posedge clk); #1;
    req_read = 1'b1; req_addr = 32'h600; req_funct3 = 3'b010;
    @(negedge clk);
    chk("to_req_stall", {31'b0, stall_o}, 32'd1);
    @(posedge clk); #1;
    req_read = 1'b0;
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.mem_req) break;
      nreq++;
      chk("to_hold_addr", bus.mem_addr, 32'h600);
    end
    chk("to_wait_cycles", nreq, 32'd4);
    chk("to_pulse", {31'b0, timeout_o}, 32'd1);
    chk("to_rdata", rdata_o, 32'd0);
    chk("to_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_clear", {31'b0, timeout_o}, 32'd0);

    // Late ack in IDLE is ignored.
    @(posedge clk); #1; man_ack = 1'b1; rdata_word = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_ack_req", {31'b0, bus.mem_req}, 32'd0);
    chk("late_ack_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1; man_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", rdata_o, 32'd0);

    // Reset in the second WAIT cycle, then a stray ack.
    @(posedge clk); #1;
    req_read = 1'b1; req_addr = 32'h700; req_funct3 = 3'b010;
    @(posedge clk); #1; req_read = 1'b0;
    @(negedge clk);
    chk("rw_req_wait1", {31'b0, bus.mem_req}, 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rw_stall_in_rst", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1; rst = 1'b0; man_ack = 1'b1; rdata_word = 32'h1234_5678;
    @(negedge clk);
    chk("rw_req_dropped", {31'b0, bus.mem_req}, 32'd0);
    chk("rw_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1; man_ack = 1'b0;
    @(negedge clk);
    chk("rw_rdata", rdata_o, 32'd0);
    chk("rw_timeout", {31'b0, timeout_o}, 32'd0);
    auto_mode = 1'b1;
    run_vec(vecs[0]);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
